// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory front end plus MEM/WB register with load extension.
// Optional alignment faults enabled by defining DM_ALIGN_EXC_EN.
module dm_access_ctrl #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic              flush,
    input  logic [3:0]        mem_type,
    input  logic [ADDR_W-1:0] mem_alu_result,
    input  logic [ADDR_W-1:0] mem_rt_data,
    input  logic [4:0]        mem_rd,
    input  logic              mem_regwrite,
    input  logic [ADDR_W-1:0] mem_pc_plus4,
    output logic [1:0]        dm_op,
    output logic [3:0]        dm_BE,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [ADDR_W-1:0] dm_MemData,
    output logic              dm_MemWrite,
    output logic [ADDR_W-1:0] dm_pc,
    input  logic [ADDR_W-1:0] dm_rdata,
    output logic              wb_regwrite,
    output logic [4:0]        wb_rd,
    output logic [ADDR_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_pc,
    output logic [1:0]        wb_exc
);

    localparam int unsigned RD_W   = 5;
    localparam int unsigned TYPE_W = 4;
    localparam int unsigned EXT_H  = ADDR_W - 16;
    localparam int unsigned EXT_B  = ADDR_W - 8;

    localparam logic [TYPE_W-1:0] MT_NONE = 4'd0;
    localparam logic [TYPE_W-1:0] MT_LW   = 4'd1;
    localparam logic [TYPE_W-1:0] MT_LH   = 4'd2;
    localparam logic [TYPE_W-1:0] MT_LHU  = 4'd3;
    localparam logic [TYPE_W-1:0] MT_LB   = 4'd4;
    localparam logic [TYPE_W-1:0] MT_LBU  = 4'd5;
    localparam logic [TYPE_W-1:0] MT_SW   = 4'd8;
    localparam logic [TYPE_W-1:0] MT_SH   = 4'd9;
    localparam logic [TYPE_W-1:0] MT_SB   = 4'd10;

    typedef struct packed {
        logic              regwrite;
        logic [RD_W-1:0]   rd;
        logic [ADDR_W-1:0] pc;
        logic [TYPE_W-1:0] mtype;
        logic [1:0]        a;
        logic [ADDR_W-1:0] payload;
        logic [1:0]        exc;
    } memwb_t;

    memwb_t     memwb_q;
    memwb_t     memwb_d;
    logic [1:0] a;
    logic       is_load;
    logic       is_store;
    logic       ld_fault;
    logic       st_fault;
    logic [3:0] be_raw;

    assign a          = mem_alu_result[1:0];
    assign dm_addr    = mem_alu_result;
    assign dm_MemData = mem_rt_data;
    assign dm_pc      = mem_pc_plus4;

    // Op decode and lane enables for the memory side
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        dm_op    = 2'd0;
        be_raw   = 4'b0000;
        case (mem_type)
            MT_LW, MT_LH, MT_LHU, MT_LB, MT_LBU: is_load = 1'b1;
            MT_SW: begin
                is_store = 1'b1;
                be_raw   = 4'b1111;
            end
            MT_SH: begin
                is_store = 1'b1;
                dm_op    = 2'd1;
                be_raw   = a[1] ? 4'b1100 : 4'b0011;
            end
            MT_SB: begin
                is_store = 1'b1;
                dm_op    = 2'd2;
                be_raw   = 4'(4'b0001 << a);
            end
            default: ;
        endcase
    end

`ifdef DM_ALIGN_EXC_EN
    always_comb begin
        ld_fault = 1'b0;
        st_fault = 1'b0;
        case (mem_type)
            MT_LW:         ld_fault = (a != 2'b00);
            MT_LH, MT_LHU: ld_fault = a[0];
            MT_SW:         st_fault = (a != 2'b00);
            MT_SH:         st_fault = a[0];
            default: ;
        endcase
    end
`else
    assign ld_fault = 1'b0;
    assign st_fault = 1'b0;
`endif

    assign dm_BE       = st_fault ? 4'b0000 : be_raw;
    // Gate on advance so a held store is written exactly once
    assign dm_MemWrite = is_store & ~st_fault & advance & ~flush & ~reset;

    always_comb begin
        memwb_d          = '0;
        memwb_d.regwrite = mem_regwrite & ~is_store & ~ld_fault;
        memwb_d.rd       = mem_rd;
        memwb_d.pc       = mem_pc_plus4;
        memwb_d.mtype    = mem_type;
        memwb_d.a        = a;
        memwb_d.payload  = is_load ? dm_rdata : mem_alu_result;
        memwb_d.exc      = {st_fault, ld_fault};
    end

    // MEM/WB register: reset and flush both load a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            memwb_q       <= '0;
            memwb_q.pc    <= ADDR_W'(RESET_PC);
            memwb_q.mtype <= MT_NONE;
        end else if (advance) begin
            if (flush) begin
                memwb_q       <= '0;
                memwb_q.pc    <= ADDR_W'(RESET_PC);
                memwb_q.mtype <= MT_NONE;
            end else begin
                memwb_q <= memwb_d;
            end
        end
    end

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Load lane selection and extension in WB
    always_comb begin
        half_sel = memwb_q.a[1] ? memwb_q.payload[31:16] : memwb_q.payload[15:0];
        byte_sel = 8'h00;
        case (memwb_q.a)
            2'd0: byte_sel = memwb_q.payload[7:0];
            2'd1: byte_sel = memwb_q.payload[15:8];
            2'd2: byte_sel = memwb_q.payload[23:16];
            2'd3: byte_sel = memwb_q.payload[31:24];
            default: ;
        endcase
        wb_data = memwb_q.payload;
        case (memwb_q.mtype)
            MT_LH:  wb_data = {{EXT_H{half_sel[15]}}, half_sel};
            MT_LHU: wb_data = {{EXT_H{1'b0}}, half_sel};
            MT_LB:  wb_data = {{EXT_B{byte_sel[7]}}, byte_sel};
            MT_LBU: wb_data = {{EXT_B{1'b0}}, byte_sel};
            default: ;
        endcase
    end

    assign wb_regwrite = memwb_q.regwrite;
    assign wb_rd       = memwb_q.regwrite ? memwb_q.rd : 5'd0;
    assign wb_pc       = memwb_q.pc;
`ifdef DM_ALIGN_EXC_EN
    assign wb_exc      = memwb_q.exc;
`else
    assign wb_exc      = 2'b00 & memwb_q.exc;
`endif

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed self-checking bench for dm_access_ctrl with a small word-array data memory.
module tb_dm_access_ctrl;

    logic        clk;
    logic        reset;
    logic        advance;
    logic        flush;
    logic [3:0]  mem_type;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_rt_data;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic [31:0] mem_pc_plus4;
    logic [1:0]  dm_op;
    logic [3:0]  dm_BE;
    logic [31:0] dm_addr;
    logic [31:0] dm_MemData;
    logic        dm_MemWrite;
    logic [31:0] dm_pc;
    logic [31:0] dm_rdata;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic [1:0]  wb_exc;

    logic [31:0] dmem [16];
    int n_cmp;
    int n_err;

    dm_access_ctrl dut (
        .clk(clk), .reset(reset), .advance(advance), .flush(flush),
        .mem_type(mem_type), .mem_alu_result(mem_alu_result),
        .mem_rt_data(mem_rt_data), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .mem_pc_plus4(mem_pc_plus4),
        .dm_op(dm_op), .dm_BE(dm_BE), .dm_addr(dm_addr),
        .dm_MemData(dm_MemData), .dm_MemWrite(dm_MemWrite), .dm_pc(dm_pc),
        .dm_rdata(dm_rdata), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_pc(wb_pc), .wb_exc(wb_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_rdata = dmem[dm_addr[5:2]];

    task automatic drive(input logic [3:0] t, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [4:0] rd, input logic rw, input logic [31:0] pc);
        mem_type       = t;
        mem_alu_result = addr;
        mem_rt_data    = rt;
        mem_rd         = rd;
        mem_regwrite   = rw;
        mem_pc_plus4   = pc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; advance = 1'b1; flush = 1'b0;
        drive(4'd8, 32'h0000_0010, 32'h5555_AAAA, 5'd4, 1'b1, 32'h0000_0044);
        n_cmp++;
        if (dm_MemWrite !== 1'b0) begin
            n_err++; $display("FAIL reset_memwrite got=%b exp=0", dm_MemWrite);
        end
        tick();
        n_cmp++;
        if ({wb_regwrite, wb_rd, wb_data, wb_pc, wb_exc} !== {1'b0, 5'd0, 32'h0, 32'h0000_3000, 2'b00}) begin
            n_err++;
            $display("FAIL reset_wb got rw=%b rd=%0d data=%h pc=%h exc=%b exp rw=0 rd=0 data=0 pc=00003000 exc=00",
                     wb_regwrite, wb_rd, wb_data, wb_pc, wb_exc);
        end
        reset = 1'b0;
    endtask

    task automatic test_store_lanes();
        drive(4'd9, 32'h0000_0006, 32'h1234_ABCD, 5'd2, 1'b1, 32'h0000_3004);
        n_cmp++;
        if ({dm_op, dm_BE, dm_MemWrite, dm_MemData, dm_addr, dm_pc} !==
            {2'd1, 4'b1100, 1'b1, 32'h1234_ABCD, 32'h0000_0006, 32'h0000_3004}) begin
            n_err++;
            $display("FAIL sh_lanes got op=%0d be=%b we=%b wd=%h addr=%h pc=%h exp op=1 be=1100 we=1 wd=1234abcd addr=6 pc=3004",
                     dm_op, dm_BE, dm_MemWrite, dm_MemData, dm_addr, dm_pc);
        end
        tick();
        drive(4'd10, 32'h0000_0007, 32'h1234_ABCD, 5'd2, 1'b1, 32'h0000_3008);
        n_cmp++;
        if ({dm_op, dm_BE, dm_MemWrite} !== {2'd2, 4'b1000, 1'b1}) begin
            n_err++; $display("FAIL sb_lanes got op=%0d be=%b we=%b exp op=2 be=1000 we=1", dm_op, dm_BE, dm_MemWrite);
        end
        tick();
        n_cmp++;
        if ({wb_regwrite, wb_rd, wb_data, wb_pc} !== {1'b0, 5'd0, 32'h0000_0007, 32'h0000_3008}) begin
            n_err++;
            $display("FAIL store_no_regwrite got rw=%b rd=%0d data=%h pc=%h exp rw=0 rd=0 data=7 pc=3008",
                     wb_regwrite, wb_rd, wb_data, wb_pc);
        end
        drive(4'd10, 32'h0000_0001, 32'h0, 5'd0, 1'b0, 32'h0000_300C);
        n_cmp++;
        if (dm_BE !== 4'b0010) begin
            n_err++; $display("FAIL sb_a1 got be=%b exp be=0010", dm_BE);
        end
        drive(4'd9, 32'h0000_0000, 32'h0, 5'd0, 1'b0, 32'h0000_300C);
        n_cmp++;
        if ({dm_op, dm_BE} !== {2'd1, 4'b0011}) begin
            n_err++; $display("FAIL sh_a0 got op=%0d be=%b exp op=1 be=0011", dm_op, dm_BE);
        end
        drive(4'd8, 32'h0000_0004, 32'h0, 5'd0, 1'b0, 32'h0000_300C);
        n_cmp++;
        if ({dm_op, dm_BE, dm_MemWrite} !== {2'd0, 4'b1111, 1'b1}) begin
            n_err++; $display("FAIL sw_lanes got op=%0d be=%b we=%b exp op=0 be=1111 we=1", dm_op, dm_BE, dm_MemWrite);
        end
        tick();
    endtask

    task automatic test_loads();
        logic [3:0]  t  [9];
        logic [31:0] ad [9];
        logic [31:0] ex [9];
        t[0] = 4'd4;  ad[0] = 32'h11;        ex[0] = 32'h0000_007F;
        t[1] = 4'd4;  ad[1] = 32'h13;        ex[1] = 32'hFFFF_FF80;
        t[2] = 4'd5;  ad[2] = 32'h12;        ex[2] = 32'h0000_00FF;
        t[3] = 4'd2;  ad[3] = 32'h12;        ex[3] = 32'hFFFF_80FF;
        t[4] = 4'd3;  ad[4] = 32'h10;        ex[4] = 32'h0000_7F01;
        t[5] = 4'd1;  ad[5] = 32'h10;        ex[5] = 32'h80FF_7F01;
        t[6] = 4'd5;  ad[6] = 32'h13;        ex[6] = 32'h0000_0080;
        t[7] = 4'd0;  ad[7] = 32'hDEAD_BEEF; ex[7] = 32'hDEAD_BEEF;
        t[8] = 4'd6;  ad[8] = 32'h0000_0013; ex[8] = 32'h0000_0013;
        for (int i = 0; i < 9; i++) begin
            drive(t[i], ad[i], 32'hFFFF_FFFF, 5'(i + 10), 1'b1, 32'h0000_4000 + 32'(i * 4));
            n_cmp++;
            if ({dm_BE, dm_MemWrite, dm_op} !== {4'b0000, 1'b0, 2'd0}) begin
                n_err++; $display("FAIL load_mem_side[%0d] got be=%b we=%b op=%0d exp be=0000 we=0 op=0", i, dm_BE, dm_MemWrite, dm_op);
            end
            tick();
            n_cmp++;
            if ({wb_data, wb_regwrite, wb_rd, wb_pc} !== {ex[i], 1'b1, 5'(i + 10), 32'h0000_4000 + 32'(i * 4)}) begin
                n_err++;
                $display("FAIL load_wb[%0d] got data=%h rw=%b rd=%0d pc=%h exp data=%h rw=1 rd=%0d pc=%h",
                         i, wb_data, wb_regwrite, wb_rd, wb_pc, ex[i], i + 10, 32'h0000_4000 + 32'(i * 4));
            end
        end
    endtask

    task automatic test_stall();
        int pulses;
        drive(4'd0, 32'hCAFE_F00D, 32'h0, 5'd9, 1'b1, 32'h0000_0200);
        tick();
        advance = 1'b0;
        drive(4'd8, 32'h0000_0020, 32'h0BAD_F00D, 5'd3, 1'b1, 32'h0000_0204);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (dm_MemWrite !== 1'b0) begin
                n_err++; $display("FAIL stall_we[%0d] got=%b exp=0", c, dm_MemWrite);
            end
            tick();
            n_cmp++;
            if ({wb_regwrite, wb_rd, wb_data, wb_pc} !== {1'b1, 5'd9, 32'hCAFE_F00D, 32'h0000_0200}) begin
                n_err++;
                $display("FAIL stall_hold[%0d] got rw=%b rd=%0d data=%h pc=%h exp rw=1 rd=9 data=cafef00d pc=200",
                         c, wb_regwrite, wb_rd, wb_data, wb_pc);
            end
        end
        advance = 1'b1;
        pulses = 0;
        #1;
        if (dm_MemWrite === 1'b1) pulses++;
        tick();
        drive(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0000_0208);
        if (dm_MemWrite === 1'b1) pulses++;
        n_cmp++;
        if (pulses != 1) begin
            n_err++; $display("FAIL stall_release_pulses got=%0d exp=1", pulses);
        end
        tick();
    endtask

    task automatic test_flush();
        flush = 1'b1;
        drive(4'd8, 32'h0000_0010, 32'h0, 5'd0, 1'b0, 32'h0000_0300);
        n_cmp++;
        if (dm_MemWrite !== 1'b0) begin
            n_err++; $display("FAIL flush_store_we got=%b exp=0", dm_MemWrite);
        end
        drive(4'd1, 32'h0000_0010, 32'h0, 5'd5, 1'b1, 32'h0000_0304);
        tick();
        flush = 1'b0;
        n_cmp++;
        if ({wb_regwrite, wb_rd, wb_data, wb_pc, wb_exc} !== {1'b0, 5'd0, 32'h0, 32'h0000_3000, 2'b00}) begin
            n_err++;
            $display("FAIL flush_bubble got rw=%b rd=%0d data=%h pc=%h exc=%b exp rw=0 rd=0 data=0 pc=3000 exc=00",
                     wb_regwrite, wb_rd, wb_data, wb_pc, wb_exc);
        end
    endtask

    task automatic test_align();
        logic [3:0]  exp_be;
        logic        exp_we;
        logic [1:0]  exp_exc_st;
        logic [1:0]  exp_exc_ld;
        logic        exp_rw;
        logic [4:0]  exp_rd;
`ifdef DM_ALIGN_EXC_EN
        exp_be = 4'b0000; exp_we = 1'b0; exp_exc_st = 2'b10; exp_exc_ld = 2'b01; exp_rw = 1'b0; exp_rd = 5'd0;
`else
        exp_be = 4'b1111; exp_we = 1'b1; exp_exc_st = 2'b00; exp_exc_ld = 2'b00; exp_rw = 1'b1; exp_rd = 5'd3;
`endif
        drive(4'd8, 32'h0000_0002, 32'h7777_7777, 5'd0, 1'b0, 32'h0000_0500);
        n_cmp++;
        if ({dm_BE, dm_MemWrite} !== {exp_be, exp_we}) begin
            n_err++; $display("FAIL align_sw got be=%b we=%b exp be=%b we=%b", dm_BE, dm_MemWrite, exp_be, exp_we);
        end
        tick();
        n_cmp++;
        if (wb_exc !== exp_exc_st) begin
            n_err++; $display("FAIL align_sw_exc got=%b exp=%b", wb_exc, exp_exc_st);
        end
        drive(4'd2, 32'h0000_0001, 32'h0, 5'd3, 1'b1, 32'h0000_0504);
        tick();
        n_cmp++;
        if ({wb_regwrite, wb_rd, wb_exc} !== {exp_rw, exp_rd, exp_exc_ld}) begin
            n_err++;
            $display("FAIL align_lh got rw=%b rd=%0d exc=%b exp rw=%b rd=%0d exc=%b",
                     wb_regwrite, wb_rd, wb_exc, exp_rw, exp_rd, exp_exc_ld);
        end
        n_cmp++;
        if (wb_data !== 32'hFFFF_8234) begin
            n_err++; $display("FAIL align_lh_data got=%h exp=ffff8234", wb_data);
        end
        drive(4'd0, 32'h0000_1234, 32'h0, 5'd6, 1'b1, 32'h0000_0508);
        tick();
        n_cmp++;
        if ({wb_exc, wb_regwrite, wb_rd, wb_data} !== {2'b00, 1'b1, 5'd6, 32'h0000_1234}) begin
            n_err++;
            $display("FAIL align_clear got exc=%b rw=%b rd=%0d data=%h exp exc=00 rw=1 rd=6 data=1234",
                     wb_exc, wb_regwrite, wb_rd, wb_data);
        end
    endtask

    task automatic test_reset_priority();
        reset = 1'b1;
        drive(4'd1, 32'h0000_0010, 32'h0, 5'd8, 1'b1, 32'h0000_0600);
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({wb_regwrite, wb_rd, wb_data, wb_pc} !== {1'b0, 5'd0, 32'h0, 32'h0000_3000}) begin
            n_err++;
            $display("FAIL reset_priority got rw=%b rd=%0d data=%h pc=%h exp rw=0 rd=0 data=0 pc=3000",
                     wb_regwrite, wb_rd, wb_data, wb_pc);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
        dmem[0] = 32'h1111_8234;
        dmem[4] = 32'h80FF_7F01;
        reset = 1'b1; advance = 1'b0; flush = 1'b0;
        mem_type = 4'd0; mem_alu_result = 32'h0; mem_rt_data = 32'h0;
        mem_rd = 5'd0; mem_regwrite = 1'b0; mem_pc_plus4 = 32'h0;
        test_reset();
        test_store_lanes();
        test_loads();
        test_stall();
        test_flush();
        test_align();
        test_reset_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- MEM-stage front end and MEM/WB pipeline register for the P6 pipelined MIPS core.
- Upstream of the data memory: decodes the memory-op type, then drives the memory's op, BE, address, store data, write strobe and pc.
- Downstream of the data memory: registers the memory's raw read word into MEM/WB and produces sign/zero-extended load data in WB.
- Non-memory instructions pass their ALU result through to writeback.

Parameters:
- ADDR_W, 32, width of the address and data paths.
- RESET_PC, 32'h0000_3000, value of wb_pc after reset or flush.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- advance  input  1  1: the MEM/WB register loads this cycle. 0: it holds.
- flush  input  1  1 with advance: MEM/WB loads a bubble.
- mem_type  input  4  memory-op code: 0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 8 sw, 9 sh, 10 sb. All other codes are treated as none.
- mem_alu_result  input  32  effective address for loads/stores; result value for other instructions.
- mem_rt_data  input  32  store data, already forwarded.
- mem_rd  input  5  destination register.
- mem_regwrite  input  1  instruction writes the register file.
- mem_pc_plus4  input  32  PC+4 of the MEM instruction.
- dm_op  output  2  to memory: 0 word, 1 half, 2 byte.
- dm_BE  output  4  to memory: byte enables.
- dm_addr  output  32  to memory: equals mem_alu_result.
- dm_MemData  output  32  to memory: equals mem_rt_data, unshifted (the memory replicates lanes).
- dm_MemWrite  output  1  to memory: write strobe.
- dm_pc  output  32  to memory: equals mem_pc_plus4.
- dm_rdata  input  32  from memory: asynchronous read word at dm_addr[13:2].
- wb_regwrite  output  1  registered write enable.
- wb_rd  output  5  registered destination register.
- wb_data  output  32  writeback value (extended load data or ALU result).
- wb_pc  output  32  registered PC+4.
- wb_exc  output  2  registered fault flags: bit0 load misaligned, bit1 store misaligned. Always 0 unless the optional feature is enabled.

Behaviour:
- Combinational MEM side, with a = mem_alu_result[1:0]:
  - sw: dm_op=0, BE=1111.
  - sh: dm_op=1, BE=0011 if a[1]=0, else 1100.
  - sb: dm_op=2, BE = 0001 << a.
  - Loads and none: BE=0000, dm_op=0.
- dm_MemWrite = store & advance & !flush & !reset. This prevents a double write while MEM is held.
- MEM/WB register captures, on a clock edge with advance=1 and flush=0:
  - regwrite, rd, pc_plus4, mem_type.
  - Low address bits a.
  - Payload: dm_rdata for loads, mem_alu_result otherwise.
- Clock edge with advance=0: all MEM/WB fields hold.
- Flush (advance=1, flush=1): regwrite=0, rd=0, type=none, payload=0, pc=RESET_PC, exc=0.
- Reset: identical to flush and has priority over advance and flush. All outputs take their reset values on the next edge: wb_regwrite=0, wb_rd=0, wb_data=0, wb_pc=RESET_PC, wb_exc=0.
- WB extension, combinational from the registered word w and registered a:
  - lw: w.
  - lh/lhu: halfword w[15:0] if a[1]=0, else w[31:16]; sign-extended for lh, zero-extended for lhu.
  - lb/lbu: byte w[8a+7:8a]; sign-extended for lb, zero-extended for lbu.
  - Non-load: payload unchanged.
- wb_rd is forced to 0 whenever wb_regwrite=0, so bypass comparators never match a bubble.
- Latency: a load's result is visible on wb_data one clock after its MEM cycle. It is available for WB→EX/MEM forwarding in that same cycle.
- Stores never set regwrite, even if mem_regwrite=1.

Optional Feature:
- Macro: DM_ALIGN_EXC_EN.
- Enabled: lw/sw with a≠0, and lh/lhu/sh with a[0]=1, are faults.
  - A faulting store forces dm_MemWrite=0 and BE=0000 and sets wb_exc[1] next cycle.
  - A faulting load forces wb_regwrite=0 and sets wb_exc[0] next cycle.
  - wb_exc clears on the next advance of a non-faulting instruction, on flush, or on reset.
- Disabled: no alignment checking.
  - Misaligned words access the word at dm_addr[13:2].
  - Halfword and byte lanes follow a as above.
  - wb_exc is tied to 0.

Test Plan:
- Reset: assert reset with advance=1 and mem_type=8 → dm_MemWrite=0; next edge wb_regwrite=0, wb_data=0, wb_pc=32'h3000.
- sh at address 0x0000_0006, rt=0x1234_ABCD → dm_op=1, BE=1100, dm_MemWrite=1. Then sb at 0x0000_0007 → BE=1000, dm_op=2.
- Word 0x80FF_7F01 in memory at 0x10:
  - lb at 0x11 → wb_data=0x0000_007F.
  - lb at 0x13 → wb_data=0xFFFF_FF80.
  - lbu at 0x12 → 0x0000_00FF.
  - lh at 0x12 → 0xFFFF_80FF.
  - lhu at 0x10 → 0x0000_7F01.
- Stall: sw with advance=0 for 3 cycles → dm_MemWrite=0 throughout and WB outputs unchanged. Raise advance → exactly one write pulse.
- Flush: lw with advance=1, flush=1 → next cycle wb_regwrite=0, wb_rd=0, wb_pc=RESET_PC.
- DM_ALIGN_EXC_EN defined: sw at 0x0000_0002 → dm_MemWrite=0, then wb_exc=10. lh at 0x0000_0001 → wb_regwrite=0, wb_exc=01. Without the macro, the same sw writes with BE=1111.
